// File: rtl/alu_pkg.sv
// Operation codes shared by the single-bit ALU slice and the word-level ALU.
// Codes 001 and 111 are reserved and always produce a zero result.
package alu_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_RSV1 = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_ADDI = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_RSV7 = 3'b111;

endpackage

// File: rtl/full_adder1.sv
// One-bit full adder on already-conditioned operands.
// It is shared by the ALU slice and the word-level ALU.
module full_adder1 (
   input  logic aa,
   input  logic bb,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = aa ^ bb ^ cin;
   assign cout = (aa & bb) | (aa & cin) | (bb & cin);

endmodule

// File: rtl/alu1.sv
// Single-bit ALU slice for a ripple-carry word ALU.
// It has a combinational result and carry, plus registered copies of both for pipelined use.
module alu1
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       b_invert,
   input  logic       a_invert,
   input  logic       less,
   input  logic [2:0] operation,
   output logic       result,
   output logic       cout,
   input  logic       clk,
   input  logic       rst_n,
   output logic       result_q,
   output logic       cout_q
);

   logic aa;
   logic bb;
   logic sum;

   assign aa = a ^ a_invert;
   assign bb = b ^ b_invert;

   // The carry is produced for every opcode, so the chain stays valid across slices.
   full_adder1 uFullAdder (
      .aa   (aa),
      .bb   (bb),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      result = 1'b0;
      case (operation)
         OP_AND:  result = aa & bb;
         OP_OR:   result = aa | bb;
         OP_XOR:  result = aa ^ bb;
         OP_ADD:  result = sum;
         OP_ADDI: result = sum;
         OP_SLT:  result = less;
         default: result = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         result_q <= result;
         cout_q   <= cout;
      end
   end

endmodule

// File: tb/tb_alu1.sv
// Self-checking bench for alu1.
// It runs directed vectors, randomized vectors checked against a behavioural model, and register/reset scenarios.
module tb_alu1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a, b, cin, b_invert, a_invert, less;
   logic [2:0] operation;
   logic       result, cout, result_q, cout_q;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic       a;
      logic       b;
      logic       cin;
      logic       binv;
      logic       ainv;
      logic       less;
      logic [2:0] op;
      logic       expR;
      logic       expC;
      logic       chkC;
   } vec_t;

   alu1 dut (
      .a         (a),
      .b         (b),
      .cin       (cin),
      .b_invert  (b_invert),
      .a_invert  (a_invert),
      .less      (less),
      .operation (operation),
      .result    (result),
      .cout      (cout),
      .clk       (clk),
      .rst_n     (rst_n),
      .result_q  (result_q),
      .cout_q    (cout_q)
   );

   always #5 clk = ~clk;

   // Reference model: the result and the carry {result, cout} computed with integer arithmetic.
   function automatic logic [1:0] refAlu(input logic ia, ib, icin, ibinv, iainv, iless,
                                         input logic [2:0] iop);
      int x, y, total, r;
      x     = iainv ? (ia ? 0 : 1) : (ia ? 1 : 0);
      y     = ibinv ? (ib ? 0 : 1) : (ib ? 1 : 0);
      total = x + y + (icin ? 1 : 0);
      case (iop)
         3'd0:    r = x * y;
         3'd2:    r = (x + y > 0) ? 1 : 0;
         3'd3:    r = (x != y) ? 1 : 0;
         3'd4:    r = total % 2;
         3'd5:    r = total % 2;
         3'd6:    r = iless ? 1 : 0;
         default: r = 0;
      endcase
      return {r[0], (total >= 2)};
   endfunction

   task automatic applyStimulus(input vec_t v);
      a         = v.a;
      b         = v.b;
      cin       = v.cin;
      b_invert  = v.binv;
      a_invert  = v.ainv;
      less      = v.less;
      operation = v.op;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus('{a:1'b1, b:1'b1, cin:1'b1, binv:1'b0, ainv:1'b0, less:1'b0,
                      op:3'b100, expR:1'b1, expC:1'b1, chkC:1'b1});
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if (result_q !== 1'b0 || cout_q !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_hold: result_q=%b cout_q=%b, required 0 0", result_q, cout_q);
      end
      testsRun++;
      if (result !== 1'b1 || cout !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_comb: result=%b cout=%b, required 1 1", result, cout);
      end
   endtask

   task automatic test_directed();
      vec_t vecs[$];
      // Fields: a b cin binv ainv less op expR expC chkC
      vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b010,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b100,1'b1,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,3'b100,1'b1,1'b1,1'b1});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b100,1'b0,1'b0,1'b1});
      vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b100,1'b1,1'b0,1'b1});
      // Subtract: 0 + ~1 + 1 leaves sum 1 and no carry.
      vecs.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,3'b100,1'b1,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'b100,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,3'b100,1'b1,1'b1,1'b1});
      vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,3'b100,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b011,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'b011,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'b110,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'b110,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b101,1'b1,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,3'b101,1'b1,1'b1,1'b1});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b101,1'b0,1'b0,1'b1});
      vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b101,1'b1,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,3'b001,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,3'b111,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'b000,1'b1,1'b1,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,3'b010,1'b0,1'b0,1'b1});
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #1;
         testsRun++;
         if (result !== vecs[i].expR) begin
            testsFailed++;
            $display("[TB] FAIL directed_result[%0d] op=%b: got %b, required %b",
                     i, vecs[i].op, result, vecs[i].expR);
         end
         if (vecs[i].chkC) begin
            testsRun++;
            if (cout !== vecs[i].expC) begin
               testsFailed++;
               $display("[TB] FAIL directed_cout[%0d] op=%b: got %b, required %b",
                        i, vecs[i].op, cout, vecs[i].expC);
            end
         end
      end
   endtask

   task automatic test_registers();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus('{a:1'b1, b:1'b1, cin:1'b1, binv:1'b0, ainv:1'b0, less:1'b0,
                      op:3'b100, expR:1'b1, expC:1'b1, chkC:1'b1});
      @(posedge clk);
      #1;
      testsRun++;
      if (result_q !== 1'b1 || cout_q !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL first_capture: result_q=%b cout_q=%b, required 1 1", result_q, cout_q);
      end
   endtask

   task automatic test_random_pipeline();
      logic [1:0] expNow;
      logic [1:0] expPrev;
      vec_t v;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         v        = '0;
         v.a      = 1'($urandom);
         v.b      = 1'($urandom);
         v.cin    = 1'($urandom);
         v.binv   = 1'($urandom);
         v.ainv   = 1'($urandom);
         v.less   = 1'($urandom);
         v.op     = 3'($urandom_range(0, 7));
         applyStimulus(v);
         expNow = refAlu(v.a, v.b, v.cin, v.binv, v.ainv, v.less, v.op);
         #1;
         testsRun++;
         if ({result, cout} !== expNow) begin
            testsFailed++;
            $display("[TB] FAIL random_comb[%0d] op=%b a=%b b=%b cin=%b ai=%b bi=%b less=%b: got %b%b, required %b",
                     i, v.op, v.a, v.b, v.cin, v.ainv, v.binv, v.less, result, cout, expNow);
         end
         expPrev = expNow;
         @(posedge clk);
         #1;
         testsRun++;
         if ({result_q, cout_q} !== expPrev) begin
            testsFailed++;
            $display("[TB] FAIL random_reg[%0d]: got %b%b, required %b", i, result_q, cout_q, expPrev);
         end
      end
   endtask

   task automatic test_reset_midcycle();
      @(negedge clk);
      applyStimulus('{a:1'b1, b:1'b1, cin:1'b1, binv:1'b0, ainv:1'b0, less:1'b0,
                      op:3'b100, expR:1'b1, expC:1'b1, chkC:1'b1});
      @(posedge clk);
      #2;
      testsRun++;
      if (result_q !== 1'b1 || cout_q !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL pre_mid_reset: result_q=%b cout_q=%b, required 1 1", result_q, cout_q);
      end
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (result_q !== 1'b0 || cout_q !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL async_clear: result_q=%b cout_q=%b, required 0 0", result_q, cout_q);
      end
      a = 1'b0;
      #1;
      testsRun++;
      if (result !== 1'b0 || cout !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL comb_during_reset: result=%b cout=%b, required 0 1", result, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_registers();
      test_random_pipeline();
      test_reset_midcycle();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
